// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the debug-port program loader: FSM states and
// frame-format constants.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader uses the slave view; the host/debug side uses the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs big-endian bytes into instruction words; word_valid pulses the
// cycle after the last byte of a word was accepted.
module byte_assembler
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  logic [1:0]        idx;
  logic [DATA_W-9:0] sr;

  assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (byte_valid) begin
        sr  <= {sr[DATA_W-17:0], byte_data};
        idx <= idx + 2'd1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {sr, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image into instruction memory, holding the
// CPU while loading and pulsing pc_reset once the image is complete.
module imem_loader
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          pc_reset,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

  state_e            state;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              last_byte;
  logic              word_valid;
  logic              last_write;
  logic [DATA_W-1:0] word;
  logic [LEN_W-1:0]  len_now;

  assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cpu_hold     = bus.in_ready;
  assign pc_reset     = (state == DONE);
  assign len_now      = {cnt[LEN_W-1:8], bus.in_data};

  assign bus.im_we    = word_valid;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = word;

  // The word being written is the last one when its address equals N-1.
  assign last_write = word_valid && (LEN_W'(addr_q) == cnt - LEN_W'(1));

  byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == LEN_LO),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (bus.in_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      widx      <= '0;
      addr_q    <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      // Address is captured with the final byte so it lines up with the word.
      if (accept && (state == DATA) && last_byte) begin
        addr_q <= widx;
        widx   <= widx + ADDR_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LEN_HI;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            cnt[LEN_W-1:8] <= bus.in_data;
            state          <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            cnt  <= len_now;
            widx <= '0;
            if (len_now == '0) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else if ({1'b0, len_now} > MAX_WORDS) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_write) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
        end
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level reference model checked
// every cycle, plus literal checks on the logged memory writes.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sel = 1'b0;   // 0: ADDR_W=8 instance, 1: ADDR_W=4 instance
  logic       chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) if8 ();
  imem_loader_if #(.ADDR_W(4)) if4 ();

  logic hold8, pcr8, done8, err8, hold4, pcr4, done4, err4;

  assign if8.in_data  = din;
  assign if8.in_valid = vld && !sel;
  assign if4.in_data  = din;
  assign if4.in_valid = vld && sel;

  imem_loader #(.ADDR_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .bus(if8),
    .cpu_hold(hold8), .pc_reset(pcr8), .load_done(done8), .load_err(err8)
  );

  imem_loader #(.ADDR_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .bus(if4),
    .cpu_hold(hold4), .pc_reset(pcr4), .load_done(done4), .load_err(err4)
  );

  logic        o_rdy, o_we, o_hold, o_pc, o_done, o_err;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;

  always_comb begin
    o_rdy   = sel ? if4.in_ready : if8.in_ready;
    o_we    = sel ? if4.im_we    : if8.im_we;
    o_addr  = sel ? {4'h0, if4.im_addr} : if8.im_addr;
    o_wdata = sel ? if4.im_wdata : if8.im_wdata;
    o_hold  = sel ? hold4 : hold8;
    o_pc    = sel ? pcr4  : pcr8;
    o_done  = sel ? done4 : done8;
    o_err   = sel ? err4  : err8;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks frame bytes consumed and derives every output
  // from the frame rules (length header, 4-byte big-endian words).
  bit          m_active, m_tail, m_lastw, m_we, m_pc, m_done, m_err;
  int          m_k;
  logic [15:0] m_n;
  logic [31:0] m_asm, m_wdata;
  logic [7:0]  m_addr;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_tail = 0; m_lastw = 0; m_we = 0; m_pc = 0;
        m_done = 0; m_err = 0; m_k = 0; m_n = '0; m_asm = '0;
        m_wdata = '0; m_addr = '0;
      end else begin
        bit acc, st, lastw_n, tail_n, pc_n, we_n;
        int aw;
        aw      = sel ? 4 : 8;
        acc     = m_active && vld;
        st      = start && !m_active && !m_tail;
        lastw_n = 0; tail_n = 0; pc_n = 0; we_n = 0;
        if (m_lastw) begin
          m_active = 0; pc_n = 1; m_done = 1; tail_n = 1;
        end else if (acc) begin
          m_k++;
          if (m_k <= 2) m_n = {m_n[7:0], din};
          if (m_k == 2) begin
            if (m_n == 16'd0) begin
              m_active = 0; pc_n = 1; m_done = 1; tail_n = 1;
            end else if (int'(m_n) > (1 << aw)) begin
              m_active = 0; m_err = 1; tail_n = 1;
            end
          end else if (m_k > 2) begin
            m_asm = {m_asm[23:0], din};
            if ((m_k - 2) % 4 == 0) begin
              we_n    = 1;
              m_addr  = 8'((m_k - 2) / 4 - 1);
              m_wdata = m_asm;
              lastw_n = (m_k == 2 + 4 * int'(m_n));
            end
          end
        end
        if (st) begin
          m_active = 1; m_k = 0; m_n = '0; m_done = 0; m_err = 0;
        end
        m_lastw = lastw_n; m_tail = tail_n; m_pc = pc_n; m_we = we_n;
      end
    end
  end

  logic [39:0] wlog[$];
  int          pc_cnt = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        check("in_ready",  64'(o_rdy),   64'(m_active));
        check("cpu_hold",  64'(o_hold),  64'(m_active));
        check("im_we",     64'(o_we),    64'(m_we));
        check("im_addr",   64'(o_addr),  64'(m_addr));
        check("im_wdata",  64'(o_wdata), 64'(m_wdata));
        check("pc_reset",  64'(o_pc),    64'(m_pc));
        check("load_done", 64'(o_done),  64'(m_done));
        check("load_err",  64'(o_err),   64'(m_err));
        if (o_we) wlog.push_back({o_addr, o_wdata});
        if (o_pc) pc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer one byte until accepted; optional idle gap first and optional
  // start pulse on the first offered cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit st);
    int guard;
    bit taken;
    guard = 0;
    taken = 0;
    if (gap) begin
      vld = 1'b0;
      step();
    end
    din   = b;
    vld   = 1'b1;
    start = st;
    while (!taken) begin
      @(negedge clk);
      taken = o_rdy;
      @(posedge clk);
      #1;
      start = 1'b0;
      guard++;
      if (!taken && guard > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL byte_timeout: byte %0h not accepted within 40 cycles", b);
        taken = 1;
      end
    end
    vld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit gaps, input int start_at);
    foreach (q[i]) send_byte(q[i], gaps && (i % 2 == 1), i == start_at);
  endtask

  task automatic clear_log();
    wlog.delete();
    pc_cnt = 0;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  logic [7:0] frame_a[$] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'h01, 8'h09, 8'h50, 8'h20};

  initial begin : stim
    logic [7:0] q[$];
    logic [31:0] w;

    // Reset values.
    idle(2);
    @(negedge clk);
    check("rst_ready", 64'(if8.in_ready), 64'd0);
    check("rst_we",    64'(if8.im_we),    64'd0);
    check("rst_addr",  64'(if8.im_addr),  64'd0);
    check("rst_wdata", 64'(if8.im_wdata), 64'd0);
    check("rst_hold",  64'(hold8), 64'd0);
    check("rst_pc",    64'(pcr8),  64'd0);
    check("rst_done",  64'(done8), 64'd0);
    check("rst_err",   64'(err8),  64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Two-word frame, continuous valid.
    clear_log();
    pulse_start();
    send_bytes(frame_a, 1'b0, -1);
    idle(4);
    check("t1_nwrites", 64'(wlog.size()), 64'd2);
    check("t1_w0", 64'(wlog[0]), {24'd0, 8'h00, 32'h20080005});
    check("t1_w1", 64'(wlog[1]), {24'd0, 8'h01, 32'h01095020});
    check("t1_pc_pulses", 64'(pc_cnt), 64'd1);
    check("t1_done", 64'(done8), 64'd1);

    // Same frame, valid toggling.
    clear_log();
    pulse_start();
    send_bytes(frame_a, 1'b1, -1);
    idle(4);
    check("t2_nwrites", 64'(wlog.size()), 64'd2);
    check("t2_w0", 64'(wlog[0]), {24'd0, 8'h00, 32'h20080005});
    check("t2_w1", 64'(wlog[1]), {24'd0, 8'h01, 32'h01095020});

    // Empty frame; start during the DONE cycle is ignored.
    clear_log();
    pulse_start();
    q = '{8'h00, 8'h00};
    send_bytes(q, 1'b0, -1);
    check("t3_pc_now", 64'(o_pc), 64'd1);
    pulse_start();
    idle(3);
    check("t3_nwrites", 64'(wlog.size()), 64'd0);
    check("t3_pc_pulses", 64'(pc_cnt), 64'd1);
    check("t3_hold_after", 64'(hold8), 64'd0);

    // Overlong frame: N = 0x0101 > 256; start during ERR is ignored.
    clear_log();
    pulse_start();
    q = '{8'h01, 8'h01};
    send_bytes(q, 1'b0, -1);
    check("t4_err_now", 64'(err8), 64'd1);
    pulse_start();
    idle(3);
    check("t4_err", 64'(err8), 64'd1);
    check("t4_done", 64'(done8), 64'd0);
    check("t4_nwrites", 64'(wlog.size()), 64'd0);
    check("t4_pc_pulses", 64'(pc_cnt), 64'd0);
    check("t4_hold", 64'(hold8), 64'd0);

    // Full-depth frame on the 16-word instance.
    chk_en = 1'b0;
    sel    = 1'b1;
    do_reset();
    chk_en = 1'b1;
    clear_log();
    q = '{8'h00, 8'h10};
    for (int i = 0; i < 16; i++) begin
      w = {8'hA0 + 8'(i), 8'h5A, 8'(i), 8'hFF - 8'(i)};
      q.push_back(w[31:24]); q.push_back(w[23:16]);
      q.push_back(w[15:8]);  q.push_back(w[7:0]);
    end
    pulse_start();
    send_bytes(q, 1'b0, -1);
    idle(4);
    check("t5_nwrites", 64'(wlog.size()), 64'd16);
    check("t5_first", 64'(wlog[0]), {24'd0, 8'h00, 32'hA05A00FF});
    check("t5_last", 64'(wlog[15]), {24'd0, 8'h0F, 32'hAF5A0FF0});
    check("t5_done", 64'(done4), 64'd1);
    check("t5_addr_hold", 64'(if4.im_addr), 64'h0F);

    // Abort by reset after 6 bytes, then a clean reload with a stray start.
    chk_en = 1'b0;
    sel    = 1'b0;
    do_reset();
    chk_en = 1'b1;
    pulse_start();
    q = frame_a[0:5];
    send_bytes(q, 1'b0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    check("ab_ready", 64'(if8.in_ready), 64'd0);
    check("ab_we",    64'(if8.im_we),    64'd0);
    check("ab_addr",  64'(if8.im_addr),  64'd0);
    check("ab_wdata", 64'(if8.im_wdata), 64'd0);
    check("ab_hold",  64'(hold8), 64'd0);
    check("ab_done",  64'(done8), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    clear_log();
    pulse_start();
    send_bytes(frame_a, 1'b0, 5);
    idle(4);
    check("t6_nwrites", 64'(wlog.size()), 64'd2);
    check("t6_w0", 64'(wlog[0]), {24'd0, 8'h00, 32'h20080005});
    check("t6_w1", 64'(wlog[1]), {24'd0, 8'h01, 32'h01095020});
    check("t6_pc_pulses", 64'(pc_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writes a program image into the CPU instruction memory from a byte stream (valid/ready), instead of a simulation-time memory preload.
- Holds the CPU halted while loading, then releases it and pulses a PC reset so execution starts at address 0.
- Sits between a host/debug byte source and the instruction memory write port.
- The CPU fetch path remains the reader of the same memory.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth 2^ADDR_W words).
- DATA_W, 32, instruction word width (fixed 4 bytes; other values unsupported).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  ADDR_W  word address to write.
- im_wdata  output  DATA_W  word to write.
- cpu_hold  output  1  CPU clock-enable low / stall while high.
- pc_reset  output  1  one-cycle pulse forcing the PC to 0.
- load_done  output  1  sticky: last load completed.
- load_err  output  1  sticky: last load rejected (length overflow).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0, pc_reset=0, load_done=0, load_err=0.
  - cpu_hold=0.
  - Reset mid-load abandons the load; words already written stay in memory.
- Byte handshake: a byte is accepted on a rising edge with in_valid&&in_ready. in_ready is a pure function of state: 1 in LEN_HI, LEN_LO and DATA; 0 otherwise. in_valid may stay high with no ready.
- Frame format: 16-bit big-endian word count N, then N words, each 4 bytes big-endian (first byte -> bits 31:24).
- States:
  - IDLE: start=1 -> LEN_HI; cpu_hold=1 from the next cycle; load_done/load_err cleared.
  - LEN_HI: accept byte -> cnt[15:8]; -> LEN_LO.
  - LEN_LO: accept byte -> cnt[7:0], then decide:
    - N=0 -> DONE.
    - N > 2^ADDR_W -> ERR.
    - otherwise -> DATA, with word index=0, byte index=0.
  - DATA: shift each accepted byte into the assembly register; byte index wraps 3->0.
    - On the 4th byte, the next cycle has im_we=1, im_addr=word index, im_wdata=assembled word (1-cycle latency).
    - Word index increments after each write.
    - After the write of word N-1 -> DONE.
    - The next frame byte may be accepted in the same cycle im_we is high.
  - DONE: one cycle with pc_reset=1; cpu_hold=0 from the same cycle; load_done=1 sticky; -> IDLE.
  - ERR: load_err=1 sticky; cpu_hold=0; pc_reset not pulsed; -> IDLE. Nothing is written on ERR.
- start while not IDLE: ignored.
- start in the same cycle as DONE/ERR: ignored (the block is only in IDLE on the following cycle).
- N = 2^ADDR_W exactly: legal; the word index reaches 2^ADDR_W-1 and never wraps.
- im_addr/im_wdata hold their last values when im_we=0.

Decomposition:
- Shared package mips_dbg_pkg:
  - State enum (IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR).
  - Constant BYTES_PER_WORD=4.
  - Width of the length field (16).
- Natural sub-module: byte_assembler (shift register + byte counter, emits word_valid).
- The FSM and address counter stay in the top.

Test Plan:
- Frame 00 02 | 20 08 00 05 | 01 09 50 20, in_valid always 1:
  - im_we pulses twice: addr 0 = 0x20080005, addr 1 = 0x01095020.
  - pc_reset pulses once; load_done=1; cpu_hold high from start+1 until the DONE cycle.
- Same frame with in_valid toggling every other cycle:
  - Identical writes.
  - No byte taken while in_valid=0.
- Frame 00 00:
  - No im_we.
  - DONE reached 1 cycle after the LEN_LO accept; pc_reset pulses.
- ADDR_W=8, N=0x0101:
  - ERR; load_err=1; no writes; cpu_hold=0; no pc_reset.
- ADDR_W=4, N=16 words:
  - Last write is addr 0xF.
  - No wrap to 0; load_done=1.
- Load aborted by rst_n=0 after 6 bytes:
  - All outputs at reset values.
  - A subsequent start + full frame loads correctly.
  - A second start mid-load is ignored.
